avalon_wait_ram: RTL and testbench

- Avalon-MM slave (responder) RAM. It is the far end of the CPU's Avalon master bus: it answers read/write with a programmable number of waitrequest stall cycles.
- Includes a clocked preload port, used by testbenches to load program words before the CPU runs.
- Sits between top_level_CPU bus pins and the testbench stimulus, as a drop-in, timing-accurate memory model with synthesizable RTL.

---
 rtl/avalon_wait_ram.sv | 131 +++++++++++++
 tb/tb_avalon_wait_ram.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/avalon_wait_ram.sv
// Avalon-MM responder RAM. Each transfer is stalled a fixed number of cycles before it is acknowledged.
// A clocked preload port fills program words while the bus is held off.
module avalon_wait_ram #(
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        write,
    input  logic        read,
    output logic        waitrequest,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    input  logic        inst_input,
    input  logic [7:0]  inst_addr,
    input  logic [31:0] instruction,
    output logic        protocol_err
);
    // state   | meaning
    // S_IDLE  | no transfer; waitrequest follows read|write
    // S_WAIT  | stalling, count_q cycles left before ACK
    // S_ACK   | transfer accepted this edge; write lanes commit
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    logic [31:0] mem [DEPTH];

    state_t              state_q, state_d;
    logic [3:0]          count_q, count_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                wr_op_q, wr_op_d;
    logic [31:0]         readdata_q, readdata_d;
    logic                perr_q, perr_d;

    logic [ADDR_W-1:0]   bus_idx;
    logic [ADDR_W-1:0]   pre_idx;
    logic [31:0]         inst_addr_w;
    logic                unused_bits;

    // Upper address bits are ignored, so the array aliases across the whole byte space.
    assign bus_idx     = address[ADDR_W+1:2];
    assign inst_addr_w = {24'd0, inst_addr};
    assign pre_idx     = inst_addr_w[ADDR_W+1:2];
    assign unused_bits = ^{address[31:ADDR_W+2], inst_addr_w[31:ADDR_W+2]};

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        wr_op_d     = wr_op_q;
        readdata_d  = readdata_q;
        perr_d      = perr_q;
        waitrequest = 1'b0;
        case (state_q)
            S_IDLE: begin
                waitrequest = read | write;
                if (inst_input) begin
                    state_d = S_IDLE;
                end else if (read && write) begin
                    waitrequest = 1'b0;
                    perr_d      = 1'b1;
                end else if (read || write) begin
                    idx_d   = bus_idx;
                    wr_op_d = write;
                    if (address[1:0] != 2'b00) perr_d = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_ACK;
                        if (read) readdata_d = mem[bus_idx];
                    end else begin
                        state_d = S_WAIT;
                        count_d = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                waitrequest = 1'b1;
                if (!read && !write) begin
                    perr_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (count_q == 4'd0) begin
                    state_d = S_ACK;
                    if (!wr_op_q) readdata_d = mem[idx_q];
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            count_q    <= 4'd0;
            idx_q      <= '0;
            wr_op_q    <= 1'b0;
            readdata_q <= 32'd0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            wr_op_q    <= wr_op_d;
            readdata_q <= readdata_d;
            perr_q     <= perr_d;
        end
    end

    // Storage has no reset; an abandoned transfer never reaches S_ACK, so it cannot commit.
    always_ff @(posedge clk) begin
        if (state_q == S_ACK && wr_op_q) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) mem[idx_q][8*b +: 8] <= writedata[8*b +: 8];
            end
        end
        if (inst_input) mem[pre_idx] <= instruction;
    end

    assign readdata     = readdata_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_avalon_wait_ram.sv
// Randomized scoreboard bench for avalon_wait_ram: the driver queues expected read data
// from a word-array reference model, and a negedge monitor pops and compares on each read ACK.
module tb_avalon_wait_ram;
    localparam int WAIT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        write, read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        inst_input;
    logic [7:0]  inst_addr;
    logic [31:0] instruction;
    logic        protocol_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [64];
    logic [31:0] exp_q [$];
    bit          perr_exp = 1'b0;

    avalon_wait_ram #(.ADDR_W(6), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .reset(reset), .address(address), .write(write), .read(read),
        .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .inst_input(inst_input), .inst_addr(inst_addr),
        .instruction(instruction), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % 64);
    endfunction

    // Monitor: a lone read with waitrequest low is an ACK cycle carrying readdata.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && read && !write && !waitrequest && !inst_input) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read_ack actual=%h expected=none", readdata);
                end else begin
                    chk("readdata", readdata, exp_q.pop_front());
                end
            end
        end
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] w);
        inst_input  = 1'b1;
        inst_addr   = a;
        instruction = w;
        @(posedge clk); #1;
        ref_mem[word_of({24'd0, a})] = w;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input bit hold);
        int  hi;
        bit  done;
        logic [31:0] w;
        address    = a;
        write      = wr;
        read       = !wr;
        writedata  = d;
        byteenable = be;
        if (!wr) exp_q.push_back(ref_mem[word_of(a)]);
        hi   = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (waitrequest) hi++;
            else done = 1'b1;
            @(posedge clk); #1;
        end
        chk("accepted", 32'(done), 32'd1);
        chk("stall_cycles", 32'(hi), 32'(WAIT + 1));
        if (wr && done) begin
            w = ref_mem[word_of(a)];
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
            ref_mem[word_of(a)] = w;
        end
        if (a[1:0] != 2'b00) perr_exp = 1'b1;
        if (!hold) begin
            read  = 1'b0;
            write = 1'b0;
        end
        chk("protocol_err", 32'(protocol_err), 32'(perr_exp));
    endtask

    task automatic do_reset();
        read  = 1'b0;
        write = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_waitrequest", 32'(waitrequest), 32'd0);
        chk("rst_protocol_err", 32'(protocol_err), 32'd0);
        perr_exp = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0; address = '0; write = 1'b0; read = 1'b0; writedata = '0;
        byteenable = '0; inst_input = 1'b0; inst_addr = '0; instruction = '0;
        do_reset();

        // Preload every word; the last preload also checks the bus is stalled.
        for (int i = 0; i < 63; i++)
            preload(8'(i * 4), (i == 1) ? 32'h2402_0010 : $urandom());
        read    = 1'b1;
        address = 32'h0000_0004;
        inst_input = 1'b1; inst_addr = 8'hFC; instruction = $urandom();
        #1;
        chk("preload_stall", 32'(waitrequest), 32'd1);
        @(posedge clk); #1;
        ref_mem[63] = instruction;
        chk("preload_hold_idle", 32'(waitrequest), 32'd1);
        read = 1'b0;
        inst_input = 1'b0;

        xfer(1'b0, 32'h0000_0004, 32'd0, 4'h0, 1'b0);
        xfer(1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'hF, 1'b0);
        xfer(1'b1, 32'h0000_0010, 32'h1122_3344, 4'h5, 1'b0);
        chk("lane_merge_model", ref_mem[4], 32'hAA22_CC44);
        xfer(1'b0, 32'h0000_0010, 32'd0, 4'h0, 1'b0);
        xfer(1'b0, 32'h0000_0110, 32'd0, 4'h0, 1'b0);
        xfer(1'b1, 32'h0000_0020, 32'h0, 4'h0, 1'b0);
        xfer(1'b0, 32'h0000_0004, 32'd0, 4'h0, 1'b1);
        xfer(1'b0, 32'h0000_0008, 32'd0, 4'h0, 1'b0);

        for (int i = 0; i < 60; i++)
            xfer(1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC, $urandom(),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        read = 1'b0; write = 1'b0;
        @(posedge clk); #1;

        xfer(1'b0, 32'h0000_0013, 32'd0, 4'h0, 1'b0);
        chk("misaligned_err", 32'(protocol_err), 32'd1);

        do_reset();
        read = 1'b1; write = 1'b1; address = 32'h0000_0010; writedata = 32'h5555_5555;
        byteenable = 4'hF;
        #1;
        chk("illegal_wait_low", 32'(waitrequest), 32'd0);
        @(posedge clk); #1;
        chk("illegal_err", 32'(protocol_err), 32'd1);
        chk("illegal_stay_idle", 32'(waitrequest), 32'd0);
        read = 1'b0; write = 1'b0;
        perr_exp = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("illegal_err_sticky", 32'(protocol_err), 32'd1);
        xfer(1'b0, 32'h0000_0010, 32'd0, 4'h0, 1'b0);

        do_reset();
        read = 1'b1; address = 32'h0000_0008;
        @(posedge clk); #1;
        read = 1'b0;
        @(posedge clk); #1;
        chk("drop_err", 32'(protocol_err), 32'd1);
        chk("drop_idle", 32'(waitrequest), 32'd0);

        do_reset();
        xfer(1'b0, 32'h0000_0004, 32'd0, 4'h0, 1'b0);
        write = 1'b1; address = 32'h0000_0020; writedata = 32'hDEAD_BEEF; byteenable = 4'hF;
        @(posedge clk);
        @(negedge clk);
        chk("wait_stall", 32'(waitrequest), 32'd1);
        #2;
        write = 1'b0;
        reset = 1'b0;
        #1;
        chk("midreset_readdata", readdata, 32'd0);
        chk("midreset_waitrequest", 32'(waitrequest), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        xfer(1'b0, 32'h0000_0020, 32'd0, 4'h0, 1'b0);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
